// File: rtl/vx_reset_sequencer_pkg.sv
// vx_reset_sequencer_pkg: sequencer states and shared counter sizing
package vx_reset_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, ASSERT, RELEASE} state_t;
    // Width of the one shared down-counter; it must hold the largest of the three loads
    function automatic int cnt_w(input int hold, input int stagger, input int drain_max);
        int m;
        m = hold > stagger ? hold : stagger;
        m = m > drain_max ? m : drain_max;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/vx_reset_sequencer.sv
// vx_reset_sequencer: holds selected reset domains, then releases them one at a time in ascending order
// Ports: clk/reset (sync, active-high); req_valid/req_mask/req_ready soft-reset request handshake;
// idle_i per-domain quiesced flags; reset_o registered per-domain resets; busy, done (pulse), timeout (sticky)
module vx_reset_sequencer
    import vx_reset_sequencer_pkg::*;
#(
    parameter int N = 4,
    parameter int HOLD = 16,
    parameter int STAGGER = 2,
    parameter int DRAIN_MAX = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic [N-1:0] req_mask,
    output logic         req_ready,
    input  logic [N-1:0] idle_i,
    output logic [N-1:0] reset_o,
    output logic         busy,
    output logic         done,
    output logic         timeout
);
    localparam int CW = cnt_w(HOLD, STAGGER, DRAIN_MAX);
    state_t state;
    logic [N-1:0] mask, low, rest;
    logic [CW-1:0] cnt;
    logic accept, drained;
    always_comb begin
        low = mask & (~mask + N'(1));
        rest = mask & ~low;
        accept = req_valid & req_ready;
        drained = (idle_i & mask) == mask;
    end
    // The reset branch preloads HOLD so the first active edge already counts; a soft reset
    // enters ASSERT one edge later through DRAIN and therefore loads HOLD-1 to keep the same hold time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ASSERT;
            mask <= '1;
            cnt <= CW'(HOLD);
            reset_o <= '1;
            busy <= 1'b1;
            done <= 1'b0;
            timeout <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        timeout <= 1'b0;
                        if (req_mask == '0) begin
                            done <= 1'b1;
                        end else begin
                            mask <= req_mask;
                            cnt <= CW'(DRAIN_MAX);
                            state <= DRAIN;
                            busy <= 1'b1;
                            req_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drained || cnt == '0) begin
                        timeout <= !drained;
                        reset_o <= reset_o | mask;
                        cnt <= CW'(HOLD - 1);
                        state <= ASSERT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    // ASSERT and RELEASE share the release step: drop the lowest pending domain when the count expires
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        reset_o <= reset_o & ~low;
                        mask <= rest;
                        cnt <= CW'(STAGGER - 1);
                        state <= rest == '0 ? IDLE : RELEASE;
                        busy <= rest != '0;
                        done <= rest == '0;
                    end
                end
            endcase
        end
    end
endmodule
